// File: rtl/sap_mar_ram.sv
// SAP-1 memory address register with 16x8 program/data RAM.
// Front-panel programming uses a debounced pushbutton for one-shot writes.
module sap_mar_ram #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address_in,
    input  logic              mar_load,
    input  logic              ram_out_en,
    input  logic              prog_mode,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_write,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    output logic              prog_busy,
    output logic              prog_done
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              sync1;
    logic              sync2;
    logic              btn_db;
    logic              btn_db_d;
    logic [CNT_W-1:0]  db_cnt;
    logic              btn_rise;
    logic              drive;

    // MAR: tracks the address switches in program mode, loads on demand in run mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q <= '0;
        end else if (prog_mode || mar_load) begin
            mar_q <= address_in;
        end
    end

    // Registered read port; RAM contents survive reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[mar_q];
        end
    end

    // RAM write port, only ever written from the programming FSM
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            mem[mar_q] <= prog_data;
        end
    end

    // Two-flop synchronizer for the raw pushbutton
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= prog_write;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_d <= btn_db;
            if (sync2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE - 1)) begin
                btn_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign btn_rise = btn_db & ~btn_db_d;

    // Programming FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Programming FSM next state and status outputs
    always_comb begin
        state_next = state;
        prog_done  = 1'b0;
        prog_busy  = 1'b0;
        unique case (state)
            IDLE: begin
                if (prog_mode && btn_rise) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                prog_done  = 1'b1;
                prog_busy  = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                prog_busy = 1'b1;
                if (!prog_mode || !btn_db) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus drive is gated by reset too so the bus floats while held in reset
    assign drive     = rst_n && ram_out_en && !prog_mode;
    assign bus_out   = drive ? rd_q : {DATA_W{1'bz}};
    assign bus_valid = drive;
    assign mar_out   = mar_q;

endmodule

// File: tb/tb_sap_mar_ram.sv
// Self-checking bench for sap_mar_ram.
// Table vectors, directed corner cases and a randomized run against a RAM model.
module tb_sap_mar_ram;

    logic       clk;
    logic       rst_n;
    logic [3:0] address_in;
    logic       mar_load;
    logic       ram_out_en;
    logic       prog_mode;
    logic [7:0] prog_data;
    logic       prog_write;
    logic [3:0] mar_out;
    wire  [7:0] bus_out;
    logic       bus_valid;
    logic       prog_busy;
    logic       prog_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    logic [7:0] ref_mem [16];
    logic [3:0] exp_mar;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    sap_mar_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address_in (address_in),
        .mar_load   (mar_load),
        .ram_out_en (ram_out_en),
        .prog_mode  (prog_mode),
        .prog_data  (prog_data),
        .prog_write (prog_write),
        .mar_out    (mar_out),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .prog_busy  (prog_busy),
        .prog_done  (prog_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_done) begin
            done_cnt++;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: prog_done high two cycles in a row");
            end
        end
        prev_done = prog_done;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_addr(input logic [3:0] a, input logic [7:0] exp);
        prog_mode  = 1'b0;
        address_in = a;
        mar_load   = 1'b1;
        ram_out_en = 1'b1;
        step();
        check("read_mar", mar_out, a);
        mar_load = 1'b0;
        step();
        check("read_valid", bus_valid, 1);
        check("read_data", bus_out, exp);
        ram_out_en = 1'b0;
        #1;
        check("read_off_valid", bus_valid, 0);
        exp_mar = a;
    endtask

    task automatic press(input logic [3:0] a, input logic [7:0] d,
                         input bit mode, input int hold, input int rel,
                         input bit expect_write);
        int d0 = done_cnt;
        prog_mode  = mode;
        mar_load   = 1'b0;
        ram_out_en = 1'b0;
        address_in = a;
        prog_data  = d;
        prog_write = 1'b1;
        repeat (hold) step();
        if (expect_write) check("busy_held", prog_busy, 1);
        prog_write = 1'b0;
        repeat (rel) step();
        check("busy_released", prog_busy, 0);
        check("done_count", done_cnt - d0, expect_write ? 1 : 0);
        if (expect_write) ref_mem[a] = d;
        if (mode) exp_mar = a;
    endtask

    initial begin
        int d0;
        logic [3:0] a;
        logic [7:0] d;

        rst_n      = 1'b0;
        address_in = 4'h0;
        mar_load   = 1'b0;
        ram_out_en = 1'b1;
        prog_mode  = 1'b0;
        prog_data  = 8'h00;
        prog_write = 1'b0;
        exp_mar    = 4'h0;

        #3;
        check("rst_mar", mar_out, 0);
        check("rst_valid", bus_valid, 0);
        check("rst_busy", prog_busy, 0);
        check("rst_done", prog_done, 0);
        repeat (3) step();
        rst_n = 1'b1;
        ram_out_en = 1'b0;
        step();

        d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            press(4'(i), 8'(8'h10 + i), 1'b1, 10, 10, 1'b1);
        end
        check("preload_pulses", done_cnt - d0, 16);

        vecs[0] = '{4'hA, 8'h1A};
        vecs[1] = '{4'h0, 8'h10};
        vecs[2] = '{4'hF, 8'h1F};
        vecs[3] = '{4'h5, 8'h15};
        vecs[4] = '{4'h3, 8'h13};
        vecs[5] = '{4'h9, 8'h19};
        for (int i = 0; i < 6; i++) begin
            read_addr(vecs[i].addr, vecs[i].exp);
        end

        d0 = done_cnt;
        prog_mode  = 1'b1;
        address_in = 4'h3;
        prog_data  = 8'hC3;
        for (int i = 0; i < 20; i++) begin
            prog_write = (i % 2 == 0);
            step();
        end
        prog_write = 1'b1;
        repeat (8) step();
        prog_write = 1'b0;
        repeat (10) step();
        check("bounce_writes", done_cnt - d0, 1);
        ref_mem[3] = 8'hC3;
        read_addr(4'h3, 8'hC3);

        d0 = done_cnt;
        prog_mode  = 1'b1;
        address_in = 4'h4;
        prog_data  = 8'hEE;
        prog_write = 1'b1;
        repeat (3) step();
        prog_write = 1'b0;
        repeat (10) step();
        check("glitch_writes", done_cnt - d0, 0);
        read_addr(4'h4, ref_mem[4]);

        prog_mode  = 1'b1;
        mar_load   = 1'b1;
        ram_out_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 4'($urandom_range(0, 15));
            address_in = a;
            mar_load   = i[0];
            step();
            check("prog_track_mar", mar_out, a);
            check("prog_bus_off", bus_valid, 0);
        end
        mar_load   = 1'b0;
        ram_out_en = 1'b0;

        press(4'h6, 8'hAB, 1'b0, 10, 10, 1'b0);
        read_addr(4'h6, ref_mem[6]);

        d0 = done_cnt;
        prog_mode  = 1'b1;
        address_in = 4'h7;
        prog_data  = 8'h77;
        prog_write = 1'b1;
        repeat (10) step();
        check("exit_busy_hold", prog_busy, 1);
        prog_mode = 1'b0;
        step();
        check("exit_busy_drop", prog_busy, 0);
        prog_mode = 1'b1;
        repeat (10) step();
        check("exit_no_rewrite", done_cnt - d0, 1);
        check("exit_busy_reenter", prog_busy, 0);
        prog_write = 1'b0;
        repeat (10) step();
        ref_mem[7] = 8'h77;
        read_addr(4'h7, 8'h77);

        d0 = done_cnt;
        prog_mode  = 1'b1;
        address_in = 4'h5;
        prog_data  = 8'h15;
        prog_write = 1'b1;
        repeat (10) step();
        check("arst_busy_before", prog_busy, 1);
        #2;
        prog_mode  = 1'b0;
        ram_out_en = 1'b1;
        prog_write = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("arst_busy", prog_busy, 0);
        check("arst_mar", mar_out, 0);
        check("arst_valid", bus_valid, 0);
        check("arst_writes", done_cnt - d0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ram_out_en = 1'b0;
        repeat (2) step();
        read_addr(4'h5, 8'h15);

        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: press(a, d, 1'b1, 10, 10, 1'b1);
                1: read_addr(a, ref_mem[a]);
                default: begin
                    prog_mode  = 1'b0;
                    mar_load   = 1'b0;
                    address_in = a;
                    step();
                    check("rand_mar_hold", mar_out, exp_mar);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_mar_ram.md
Name: sap_mar_ram

Overview:
- Memory address register (MAR) plus 16x8 program/data RAM for the SAP-1 datapath.
- Sits directly downstream of the 2:1 4-bit address mux. In run mode the mux output is the bus address and is captured on mar_load. In program mode it is the front-panel address switches, tracked continuously.
- Supplies instruction/operand bytes to the shared W bus.
- Owns front-panel programming: debounced write pushbutton, one-shot RAM write.

Parameters:
- ADDR_W, 4, address width; mux output width.
- DATA_W, 8, RAM word and bus width.
- DEPTH, 16, number of RAM words (2**ADDR_W).
- DEBOUNCE, 4, consecutive stable synchronized samples required to accept a pushbutton level change.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address_in  input  ADDR_W  address from the 2:1 address mux output.
- mar_load  input  1  run mode: capture address_in into MAR.
- ram_out_en  input  1  run mode: drive RAM word onto bus_out.
- prog_mode  input  1  1 = front-panel programming, 0 = run.
- prog_data  input  DATA_W  front-panel data switches.
- prog_write  input  1  raw, asynchronous, bouncy write pushbutton (active high).
- mar_out  output  ADDR_W  current MAR contents.
- bus_out  output  DATA_W  RAM read data when enabled; otherwise all z.
- bus_valid  output  1  1 while bus_out is actively driven.
- prog_busy  output  1  1 from write acceptance until button release is debounced.
- prog_done  output  1  one-cycle pulse in the cycle the RAM write occurs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - mar_out=0, read register=0, bus_out=z, bus_valid=0, prog_busy=0, prog_done=0.
  - FSM returns to IDLE; synchronizer and debounce counter are cleared.
  - RAM contents are NOT cleared.
- MAR update:
  - prog_mode=0: MAR<=address_in on the edge where mar_load=1; otherwise it holds.
  - prog_mode=1: MAR<=address_in every cycle; mar_load is ignored.
- Read:
  - Registered: rd_q<=mem[MAR] every cycle.
  - Data for a new MAR value appears on rd_q one cycle after the MAR update (2 edges after mar_load).
- Bus drive:
  - bus_out=rd_q and bus_valid=1 only when ram_out_en=1 and prog_mode=0; otherwise bus_out=z and bus_valid=0.
  - Combinational from ram_out_en/prog_mode, so there is no turn-on latency.
- prog_write conditioning:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level btn_db changes only after DEBOUNCE consecutive synchronized samples that differ from the current btn_db.
  - Any sample equal to btn_db resets the counter.
- Programming FSM:
  - IDLE: if prog_mode=1 and btn_db rises -> WRITE.
  - WRITE (exactly 1 cycle): mem[MAR]<=prog_data, prog_done=1, prog_busy=1 -> HOLD.
  - HOLD: prog_busy=1; when btn_db=0 -> IDLE.
  - prog_mode dropping to 0 in HOLD -> IDLE immediately; no further write.
  - A btn_db rise while prog_mode=0 is ignored and does not arm a later write.
- Minimum button latency: the raw press must be stable for 2+DEBOUNCE cycles before the write edge.
- One write per press; holding the button never re-writes.
- Simultaneous write and read:
  - The written address reads new data on rd_q the cycle after WRITE (write-first is not required).
  - The bus is z in prog_mode anyway.
- MAR wraps naturally (4-bit); no out-of-range addresses exist.
- Reset asserted mid-HOLD or mid-debounce: the FSM aborts to IDLE. The RAM word already written stays written.

Test Plan:
- Reset then preload: program addresses 0..15 with data 8'h10+addr via prog_mode=1. Each press is held 10 cycles, then released 10 cycles. Required: exactly 16 prog_done pulses, each 1 cycle wide, with prog_busy high until release is debounced.
- Run read: prog_mode=0, address_in=4'hA, mar_load=1 for one cycle, ram_out_en=1. Required: mar_out=4'hA after the 1st edge and bus_out=8'h1A after the 2nd edge with bus_valid=1. ram_out_en=0 gives bus_out=8'hzz.
- Bounce rejection: toggle prog_write every cycle for 20 cycles, then hold high 8 cycles at address 3 with prog_data=8'hC3. Required: exactly one write, with mem[3]=8'hC3. A 3-cycle glitch alone produces no prog_done.
- Ignored inputs: in prog_mode=1, pulse mar_load with ram_out_en=1. Required: bus_out stays z and mar_out tracks address_in every cycle. In prog_mode=0, press prog_write. Required: no write; mem unchanged.
- Mode exit mid-press: enter HOLD, drop prog_mode while the button is held. Required: prog_busy=0 the next cycle and no second write on re-entering prog_mode while still held.
- Async reset: assert rst_n=0 mid-HOLD, between edges. Required: prog_busy, mar_out and bus_valid go to 0 immediately. After release, reading address 5 still returns 8'h15.
